spear_wave_scheduler: RTL and testbench



---
 rtl/spear_wave_scheduler_pkg.sv | 28 ++
 rtl/spear_wave_scheduler_rom.sv | 41 ++++
 rtl/spear_wave_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_spear_wave_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spear_wave_scheduler_pkg.sv
// Shared types for the enemy spear wave scheduler: wave table entry, FSM states, directions.
package spear_sched_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef struct packed {
        logic [1:0] dir;
        logic [2:0] speed;
        logic [5:0] delay;
        logic       last;
    } wave_entry_t;

    localparam int WAVE_W = $bits(wave_entry_t);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_WAIT,
        ST_ALLOC,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/spear_wave_scheduler_rom.sv
// wave_pattern_rom: per-turn wave table, registered read (data valid one cycle after address).
module wave_pattern_rom
    import spear_sched_pkg::*;
#(
    parameter int TURN_W = 4,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic [TURN_W-1:0] turn_i,
    input  logic [IDX_W-1:0]  wave_i,
    output logic [WAVE_W-1:0] entry_o
);

    // Turn 0 is hand-authored; other turns come from a simple arithmetic pattern.
    function automatic wave_entry_t lookup(input logic [TURN_W-1:0] t, input logic [IDX_W-1:0] w);
        wave_entry_t e;
        if (t == '0) begin
            case (32'(w))
                0:       e = '{dir: DIR_UP,    speed: 3'd2, delay: 6'd0, last: 1'b0};
                1:       e = '{dir: DIR_LEFT,  speed: 3'd3, delay: 6'd4, last: 1'b0};
                2:       e = '{dir: DIR_RIGHT, speed: 3'd1, delay: 6'd0, last: 1'b1};
                default: e = '{dir: DIR_UP,    speed: 3'd1, delay: 6'd0, last: 1'b1};
            endcase
        end else begin
            e.dir   = 2'(32'(t) + 32'(w));
            e.speed = 3'((32'(w) % 5) + 1);
            e.delay = 6'((2 * 32'(t)) + 32'(w));
            e.last  = (32'(w) == ((32'(t) % 4) + 2));
        end
        return e;
    endfunction

    logic [WAVE_W-1:0] entry_q;

    always_ff @(posedge clk) begin
        entry_q <= lookup(turn_i, wave_i);
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/spear_wave_scheduler.sv
// Enemy-phase spear wave sequencer: waits per-wave delays, allocates slots, issues spawn pulses.
// Optional drain watchdog enabled by defining SPEAR_SCHED_TIMEOUT_EN.
module spear_wave_scheduler
    import spear_sched_pkg::*;
#(
    parameter int NUM_SLOTS      = 4,
    parameter int NUM_TURNS      = 9,
    parameter int WAVES_PER_TURN = 8,
    parameter int TIMEOUT_FRAMES = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_tick_in,
    input  logic                         start_in,
    input  logic [3:0]                   turn_in,
    input  logic [NUM_SLOTS-1:0]         slot_busy_in,
    output logic                         spawn_valid_out,
    output logic [$clog2(NUM_SLOTS)-1:0] spawn_slot_out,
    output logic [1:0]                   spawn_dir_out,
    output logic [2:0]                   spawn_speed_out,
    output logic                         busy_out,
    output logic                         finished_out,
    output logic                         timeout_out
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int IDX_W  = (WAVES_PER_TURN > 1) ? $clog2(WAVES_PER_TURN) : 1;
    localparam int CNT_W  = (TIMEOUT_FRAMES > 63) ? $clog2(TIMEOUT_FRAMES + 1) : 6;

    state_e             state_q, state_d;
    logic [3:0]         turn_q, turn_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    wave_entry_t        entry_q, entry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0] reserved_q, reserved_d;
    logic               spawn_valid_q, spawn_valid_d;
    logic [SLOT_W-1:0]  spawn_slot_q, spawn_slot_d;
    logic [1:0]         spawn_dir_q, spawn_dir_d;
    logic [2:0]         spawn_speed_q, spawn_speed_d;
    logic               busy_q, busy_d;
    logic               finished_q, finished_d;

    logic [WAVE_W-1:0]  rom_data;
    wave_entry_t        rom_entry;
    logic [NUM_SLOTS-1:0] free_slots;
    logic               alloc_found;
    logic [SLOT_W-1:0]  alloc_slot;

    wave_pattern_rom #(
        .TURN_W (4),
        .IDX_W  (IDX_W)
    ) u_rom (
        .clk     (clk),
        .turn_i  (turn_q),
        .wave_i  (idx_q),
        .entry_o (rom_data)
    );

    assign rom_entry = wave_entry_t'(rom_data);

    // A slot stays reserved from its spawn until the datapath first reports it busy.
    assign free_slots = ~slot_busy_in & ~reserved_q;

    always_comb begin
        alloc_found = 1'b0;
        alloc_slot  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (free_slots[i]) begin
                alloc_found = 1'b1;
                alloc_slot  = SLOT_W'(i);
            end
        end
    end

`ifdef SPEAR_SCHED_TIMEOUT_EN
    logic timeout_q, timeout_d;
`endif

    always_comb begin
        state_d       = state_q;
        turn_d        = turn_q;
        idx_d         = idx_q;
        entry_d       = entry_q;
        cnt_d         = cnt_q;
        reserved_d    = reserved_q & ~slot_busy_in;
        spawn_valid_d = 1'b0;
        spawn_slot_d  = '0;
        spawn_dir_d   = '0;
        spawn_speed_d = '0;
`ifdef SPEAR_SCHED_TIMEOUT_EN
        timeout_d     = timeout_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    turn_d = turn_in;
                    idx_d  = '0;
`ifdef SPEAR_SCHED_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d = ({28'd0, turn_in} >= 32'(NUM_TURNS)) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                entry_d = rom_entry;
                cnt_d   = '0;
                state_d = (rom_entry.delay == 6'd0) ? ST_ALLOC : ST_WAIT;
            end
            ST_WAIT: begin
                if (frame_tick_in) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(entry_q.delay)) state_d = ST_ALLOC;
                end
            end
            ST_ALLOC: begin
                if (alloc_found) begin
                    spawn_valid_d          = 1'b1;
                    spawn_slot_d           = alloc_slot;
                    spawn_dir_d            = entry_q.dir;
                    spawn_speed_d          = entry_q.speed;
                    reserved_d[alloc_slot] = 1'b1;
                    if (entry_q.last || (idx_q == IDX_W'(WAVES_PER_TURN - 1))) begin
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DRAIN: begin
                if ((slot_busy_in == '0) && (reserved_q == '0)) begin
                    state_d = ST_DONE;
                end
`ifdef SPEAR_SCHED_TIMEOUT_EN
                else if (frame_tick_in) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT_FRAMES)) begin
                        reserved_d = '0;
                        timeout_d  = 1'b1;
                        state_d    = ST_DONE;
                    end
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d     = (state_d != ST_IDLE);
        finished_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            turn_q        <= '0;
            idx_q         <= '0;
            entry_q       <= '0;
            cnt_q         <= '0;
            reserved_q    <= '0;
            spawn_valid_q <= 1'b0;
            spawn_slot_q  <= '0;
            spawn_dir_q   <= '0;
            spawn_speed_q <= '0;
            busy_q        <= 1'b0;
            finished_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            turn_q        <= turn_d;
            idx_q         <= idx_d;
            entry_q       <= entry_d;
            cnt_q         <= cnt_d;
            reserved_q    <= reserved_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_slot_q  <= spawn_slot_d;
            spawn_dir_q   <= spawn_dir_d;
            spawn_speed_q <= spawn_speed_d;
            busy_q        <= busy_d;
            finished_q    <= finished_d;
        end
    end

`ifdef SPEAR_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) timeout_q <= 1'b0;
        else     timeout_q <= timeout_d;
    end
    assign timeout_out = timeout_q;
`else
    assign timeout_out = 1'b0;
`endif

    assign spawn_valid_out = spawn_valid_q;
    assign spawn_slot_out  = spawn_slot_q;
    assign spawn_dir_out   = spawn_dir_q;
    assign spawn_speed_out = spawn_speed_q;
    assign busy_out        = busy_q;
    assign finished_out    = finished_q;

endmodule

// File: tb/tb_spear_wave_scheduler.sv
// Directed bench for spear_wave_scheduler with a spawn scoreboard and a simple slot flight model.
module tb_spear_wave_scheduler;
    import spear_sched_pkg::*;

    localparam int NUM_SLOTS = 4;

    logic       clk;
    logic       rst;
    logic       frame_tick_in;
    logic       start_in;
    logic [3:0] turn_in;
    logic [3:0] slot_busy_in;
    logic       spawn_valid_out;
    logic [1:0] spawn_slot_out;
    logic [1:0] spawn_dir_out;
    logic [2:0] spawn_speed_out;
    logic       busy_out;
    logic       finished_out;
    logic       timeout_out;

    spear_wave_scheduler #(
        .NUM_SLOTS      (NUM_SLOTS),
        .NUM_TURNS      (9),
        .WAVES_PER_TURN (8),
        .TIMEOUT_FRAMES (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .frame_tick_in   (frame_tick_in),
        .start_in        (start_in),
        .turn_in         (turn_in),
        .slot_busy_in    (slot_busy_in),
        .spawn_valid_out (spawn_valid_out),
        .spawn_slot_out  (spawn_slot_out),
        .spawn_dir_out   (spawn_dir_out),
        .spawn_speed_out (spawn_speed_out),
        .busy_out        (busy_out),
        .finished_out    (finished_out),
        .timeout_out     (timeout_out)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- environment models ----------------
    logic       tick_en;
    int         tick_div;
    always @(posedge clk) begin
        if (rst || !tick_en) begin
            tick_div      <= 0;
            frame_tick_in <= 1'b0;
        end else if (tick_div == 9) begin
            tick_div      <= 0;
            frame_tick_in <= 1'b1;
        end else begin
            tick_div      <= tick_div + 1;
            frame_tick_in <= 1'b0;
        end
    end

    int         fly_len;
    int         fly_cnt [NUM_SLOTS];
    logic [3:0] fly_q;
    logic [3:0] stuck_mask;
    always @(posedge clk) begin
        if (rst) begin
            fly_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) fly_cnt[i] <= 0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (spawn_valid_out && (int'(spawn_slot_out) == i)) begin
                    fly_q[i]   <= 1'b1;
                    fly_cnt[i] <= fly_len;
                end else if (fly_cnt[i] > 0) begin
                    fly_cnt[i] <= fly_cnt[i] - 1;
                    if (fly_cnt[i] == 1) fly_q[i] <= 1'b0;
                end
            end
        end
    end
    assign slot_busy_in = fly_q | stuck_mask;

    // ---------------- scoreboard ----------------
    logic [6:0] exp_q[$];
    int tests;
    int fails;
    int ncyc;
    int spawn_cnt;
    int last_spawn;
    int fin_cnt;
    int tick_cnt;

    function automatic logic [6:0] pk(input int slot, input logic [1:0] dir, input int speed);
        return {2'(slot), dir, 3'(speed)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: sample outputs at the falling edge and score any spawn.
    task automatic step();
        logic [6:0] got;
        logic [6:0] want;
        @(negedge clk);
        ncyc++;
        got = {spawn_slot_out, spawn_dir_out, spawn_speed_out};
        if (spawn_valid_out) begin
            spawn_cnt++;
            last_spawn = ncyc;
            check("spawn_expected", 32'(exp_q.size() != 0), 1);
            want = 7'h7f;
            if (exp_q.size() != 0) want = exp_q.pop_front();
            check("spawn_fields", 32'(got), 32'(want));
        end else begin
            check("idle_fields", 32'(got), 0);
        end
        if (finished_out) fin_cnt++;
        if (frame_tick_in) tick_cnt++;
    endtask

    task automatic wait_spawn(input string tag, input int bound);
        int c0;
        int n;
        c0 = spawn_cnt;
        n  = 0;
        while ((spawn_cnt == c0) && (n < bound)) begin
            step();
            n++;
        end
        check(tag, 32'(spawn_cnt - c0), 1);
    endtask

    task automatic wait_finish(input string tag, input int bound);
        int c0;
        int n;
        c0 = fin_cnt;
        n  = 0;
        while ((fin_cnt == c0) && (n < bound)) begin
            step();
            n++;
        end
        check(tag, 32'(fin_cnt - c0), 1);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        start_in   = 1'b0;
        stuck_mask = '0;
        tick_en    = 1'b0;
        step();
        step();
        check("reset_outputs", {spawn_valid_out, spawn_slot_out, spawn_dir_out, spawn_speed_out,
                                busy_out, finished_out, timeout_out}, 0);
        rst = 1'b0;
        exp_q.delete();
        step();
        tick_en = 1'b1;
    endtask

    int n_start;
    task automatic start_turn(input logic [3:0] t);
        start_in = 1'b1;
        turn_in  = t;
        n_start  = ncyc;
        step();
        start_in = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    int s_cyc;
    int nt;
    int t_four;
    int guard;
    int f0;
    int s0;
    int t0;

    initial begin
        tests = 0; fails = 0; ncyc = 0; spawn_cnt = 0; last_spawn = 0; fin_cnt = 0; tick_cnt = 0;
        rst = 1'b1; start_in = 1'b0; turn_in = '0; stuck_mask = '0; tick_en = 1'b0; fly_len = 150;
        do_reset();

        // Turn 0, all slots idle
        exp_q.push_back(pk(0, DIR_UP, 2));
        exp_q.push_back(pk(1, DIR_LEFT, 3));
        exp_q.push_back(pk(2, DIR_RIGHT, 1));
        start_turn(4'd0);
        check("t1_busy_n1", 32'(busy_out), 1);
        wait_spawn("t1_spawn0_seen", 10);
        check("t1_first_latency", 32'(last_spawn - n_start), 4);
        s_cyc = last_spawn; nt = 0; t_four = 0; guard = 0;
        while ((spawn_cnt == 1) && (guard < 200)) begin
            step();
            guard++;
            if (frame_tick_in && (ncyc >= s_cyc + 2) && (nt < 4)) begin
                nt++;
                if (nt == 4) t_four = ncyc;
            end
        end
        check("t1_spawn1_seen", 32'(spawn_cnt), 2);
        check("t1_spawn1_time", 32'(last_spawn), 32'(t_four + 2));
        s_cyc = last_spawn;
        wait_spawn("t1_spawn2_seen", 10);
        check("t1_gap", 32'(last_spawn - s_cyc), 3);
        wait_finish("t1_finish", 400);
        check("t1_busy_at_finish", 32'(busy_out), 1);
        step();
        check("t1_idle_after", {30'd0, busy_out, finished_out}, 0);
        check("t1_exp_empty", 32'(exp_q.size()), 0);

        // Out-of-range turn
        do_reset();
        s0 = spawn_cnt;
        start_turn(4'd9);
        check("t3_n1", {30'd0, busy_out, finished_out}, 32'b11);
        step();
        check("t3_n2", {30'd0, busy_out, finished_out}, 0);
        repeat (10) step();
        check("t3_no_spawn", 32'(spawn_cnt - s0), 0);

        // All slots busy, then slot 1 frees
        do_reset();
        stuck_mask = 4'b1111;
        exp_q.push_back(pk(1, DIR_UP, 2));
        exp_q.push_back(pk(0, DIR_LEFT, 3));
        exp_q.push_back(pk(2, DIR_RIGHT, 1));
        s0 = spawn_cnt;
        start_turn(4'd0);
        repeat (20) step();
        check("t2_stalled", 32'(spawn_cnt - s0), 0);
        stuck_mask = 4'b1101;
        step();
        check("t2_spawn_next", 32'(spawn_valid_out), 1);
        stuck_mask = 4'b0000;
        wait_spawn("t2_spawn1_seen", 200);
        wait_spawn("t2_spawn2_seen", 10);
        wait_finish("t2_finish", 400);
        check("t2_exp_empty", 32'(exp_q.size()), 0);

        // Second start while waiting is ignored
        do_reset();
        exp_q.push_back(pk(0, DIR_UP, 2));
        exp_q.push_back(pk(1, DIR_LEFT, 3));
        exp_q.push_back(pk(2, DIR_RIGHT, 1));
        f0 = fin_cnt;
        start_turn(4'd0);
        wait_spawn("t4_spawn0_seen", 10);
        repeat (4) step();
        start_in = 1'b1;
        turn_in  = 4'd9;
        step();
        start_in = 1'b0;
        turn_in  = 4'd0;
        check("t4_no_early_finish", 32'(finished_out), 0);
        wait_spawn("t4_spawn1_seen", 200);
        wait_spawn("t4_spawn2_seen", 10);
        wait_finish("t4_finish", 400);
        check("t4_one_finish", 32'(fin_cnt - f0), 1);
        check("t4_exp_empty", 32'(exp_q.size()), 0);

        // Reset between first and second spawn
        do_reset();
        exp_q.push_back(pk(0, DIR_UP, 2));
        start_turn(4'd0);
        wait_spawn("t5_spawn0_seen", 10);
        repeat (3) step();
        rst = 1'b1;
        step();
        check("t5_outputs_after_rst", {spawn_valid_out, spawn_slot_out, spawn_dir_out, spawn_speed_out,
                                       busy_out, finished_out, timeout_out}, 0);
        rst = 1'b0;
        exp_q.delete();
        step();
        exp_q.push_back(pk(0, DIR_UP, 2));
        exp_q.push_back(pk(1, DIR_LEFT, 3));
        exp_q.push_back(pk(2, DIR_RIGHT, 1));
        start_turn(4'd0);
        wait_spawn("t5_restart_seen", 10);
        check("t5_restart_latency", 32'(last_spawn - n_start), 4);
        wait_spawn("t5_spawn1_seen", 200);
        wait_spawn("t5_spawn2_seen", 10);
        wait_finish("t5_finish", 400);

        // Slot 2 stuck busy during drain
        do_reset();
        exp_q.push_back(pk(0, DIR_UP, 2));
        exp_q.push_back(pk(1, DIR_LEFT, 3));
        exp_q.push_back(pk(2, DIR_RIGHT, 1));
        start_turn(4'd0);
        wait_spawn("t6_spawn0_seen", 10);
        wait_spawn("t6_spawn1_seen", 200);
        wait_spawn("t6_spawn2_seen", 10);
        stuck_mask = 4'b0100;
        t0 = tick_cnt - (frame_tick_in ? 1 : 0);
        f0 = fin_cnt;
`ifdef SPEAR_SCHED_TIMEOUT_EN
        wait_finish("t6_timeout_finish", 300);
        check("t6_drain_ticks", 32'(tick_cnt - t0), 8);
        check("t6_timeout_set", 32'(timeout_out), 1);
        step();
        check("t6_timeout_sticky", 32'(timeout_out), 1);
        start_turn(4'd9);
        check("t6_timeout_cleared", 32'(timeout_out), 0);
`else
        repeat (300) step();
        check("t6_no_finish", 32'(fin_cnt - f0), 0);
        check("t6_timeout_low", 32'(timeout_out), 0);
        check("t6_still_busy", 32'(busy_out), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
